// File: rtl/comp_cond_pkg.sv
// Shared types and sizing helpers for the comparator conditioner.
package comp_cond_pkg;

    localparam int unsigned FILT_CNT_W = 16;

    typedef enum logic [1:0] {STABLE, QUALIFY, BLANK} state_t;

    // Blank counter must hold BLANK_TICKS; never narrower than one bit.
    function automatic int unsigned blank_cnt_w(input int unsigned ticks);
        int unsigned w;
        w = $clog2(ticks + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/comp_conditioner_sync_chain.sv
// Parameterised N-stage flop synchroniser for asynchronous input pins.
module sync_chain #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned WIDTH  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], d};
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/comp_conditioner.sv
// Comparator front end: synchronise, qualify pulse width, blank after PWM/DAC changes.
module comp_conditioner
    import comp_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned FILTER_TICKS = 16,
    parameter int unsigned BLANK_TICKS  = 64,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             comp_raw,
    input  logic             blank_start,
    input  logic             clear_count,
    output logic             comp_clean,
    output logic             comp_rise,
    output logic             comp_fall,
    output logic             blanking,
    output logic [CNT_W-1:0] glitch_count
);

    localparam int unsigned BLANK_W = blank_cnt_w(BLANK_TICKS);
    localparam logic [FILT_CNT_W-1:0] FILT_TGT   = FILT_CNT_W'(FILTER_TICKS);
    localparam logic [BLANK_W-1:0]    BLANK_LOAD = BLANK_W'(BLANK_TICKS);

    logic sync;

    sync_chain #(
        .STAGES(SYNC_STAGES),
        .WIDTH (1)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (comp_raw),
        .q    (sync)
    );

    state_t                state_q, state_d;
    logic [FILT_CNT_W-1:0] filt_cnt_q, filt_cnt_d;
    logic [BLANK_W-1:0]    blank_cnt_q, blank_cnt_d;
    logic                  clean_q, clean_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;
    logic                  blanking_q, blanking_d;
    logic [CNT_W-1:0]      glitch_q, glitch_d;
    logic                  glitch_inc;
    logic [FILT_CNT_W-1:0] filt_inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= STABLE;
            filt_cnt_q  <= '0;
            blank_cnt_q <= '0;
            clean_q     <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            blanking_q  <= 1'b0;
            glitch_q    <= '0;
        end else begin
            state_q     <= state_d;
            filt_cnt_q  <= filt_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            clean_q     <= clean_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            blanking_q  <= blanking_d;
            glitch_q    <= glitch_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        filt_cnt_d  = filt_cnt_q;
        blank_cnt_d = blank_cnt_q;
        clean_d     = clean_q;
        rise_d      = 1'b0;
        fall_d      = 1'b0;
        glitch_inc  = 1'b0;
        glitch_d    = glitch_q;
        filt_inc    = filt_cnt_q + FILT_CNT_W'(1);

        // A new blanking request overrides everything, including a pending qualification.
        if (blank_start && (BLANK_TICKS != 0)) begin
            state_d     = BLANK;
            blank_cnt_d = BLANK_LOAD;
            filt_cnt_d  = '0;
        end else begin
            case (state_q)
                STABLE: begin
                    filt_cnt_d = '0;
                    if (sync != clean_q) begin
                        if (FILT_TGT == FILT_CNT_W'(1)) begin
                            clean_d = sync;
                            rise_d  = sync;
                            fall_d  = ~sync;
                        end else begin
                            state_d    = QUALIFY;
                            filt_cnt_d = FILT_CNT_W'(1);
                        end
                    end
                end
                QUALIFY: begin
                    if (sync != clean_q) begin
                        if (filt_inc == FILT_TGT) begin
                            clean_d    = sync;
                            rise_d     = sync;
                            fall_d     = ~sync;
                            state_d    = STABLE;
                            filt_cnt_d = '0;
                        end else begin
                            filt_cnt_d = filt_inc;
                        end
                    end else begin
                        filt_cnt_d = '0;
                        glitch_inc = 1'b1;
                        state_d    = STABLE;
                    end
                end
                BLANK: begin
                    filt_cnt_d = '0;
                    if (blank_cnt_q <= BLANK_W'(1)) begin
                        blank_cnt_d = '0;
                        state_d     = STABLE;
                    end else begin
                        blank_cnt_d = blank_cnt_q - BLANK_W'(1);
                    end
                end
                default: begin
                    state_d    = STABLE;
                    filt_cnt_d = '0;
                end
            endcase
        end

        if (clear_count) begin
            glitch_d = '0;
        end else if (glitch_inc && (glitch_q != '1)) begin
            glitch_d = glitch_q + CNT_W'(1);
        end

        blanking_d = (state_d == BLANK);
    end

    assign comp_clean   = clean_q;
    assign comp_rise    = rise_q;
    assign comp_fall    = fall_q;
    assign blanking     = blanking_q;
    assign glitch_count = glitch_q;

endmodule

// File: doc/comp_conditioner.md
# comp_conditioner

Front-end conditioner for the analog comparator output that feeds both the ramp and SAR conversion paths of the PWM ADC. It synchronises the asynchronous `comp_raw` pin, rejects pulses shorter than a programmable qualification time, and ignores the comparator entirely for a blanking window after each PWM duty/DAC-code change while the RC filter settles. It emits a clean level, single-cycle edge strobes and a saturating glitch counter for diagnostics. It sits directly upstream of the PWM ADC subsystem, whose comparator input it drives.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser depth; legal values are 2 or more.
- `FILTER_TICKS`, 16: consecutive stable cycles required before `comp_clean` changes; legal range 1..65535.
- `BLANK_TICKS`, 64: blanking window length in cycles; 0 disables blanking.
- `CNT_W`, 16: width of `glitch_count`.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-high reset. The design has one clock.
- `comp_raw` in 1: asynchronous comparator pin.
- `blank_start` in 1: single-cycle pulse raised when the PWM duty or DAC code changes.
- `clear_count` in 1: synchronous clear of `glitch_count`.
- `comp_clean` out 1: filtered comparator level.
- `comp_rise` out 1: one-cycle strobe when `comp_clean` goes 0→1.
- `comp_fall` out 1: one-cycle strobe when `comp_clean` goes 1→0.
- `blanking` out 1: high while the blanking window is active.
- `glitch_count` out CNT_W: count of rejected pulses; saturates at all-ones.

## Operation
- Synchroniser: a chain of `SYNC_STAGES` flops resets to 0. `sync` is the last stage of the chain.
- The FSM uses three states from `comp_cond_pkg::state_t`:
  - STABLE: `sync == comp_clean`, and the counter is held at 0.
    - If `sync != comp_clean`, go to QUALIFY with count = 1.
  - QUALIFY: the counter increments each cycle while `sync != comp_clean`.
    - When the count reaches `FILTER_TICKS`, toggle `comp_clean`, pulse the matching edge strobe, and return to STABLE.
    - If `sync` returns to `comp_clean` first, clear the count, increment `glitch_count` by 1 (saturating), and return to STABLE.
  - BLANK: entered from any state on `blank_start` when `BLANK_TICKS > 0`.
    - The blank counter loads `BLANK_TICKS`; `comp_clean` is frozen and the filter count is forced to 0.
    - There are no glitch increments and no edge strobes.
    - Exit to STABLE when the blank counter reaches 0.
- `blank_start` while in BLANK reloads the window to the full `BLANK_TICKS`. This is a retrigger, not an extension.
- `blank_start` while in QUALIFY aborts qualification. The aborted pulse is not counted as a glitch.
- With `FILTER_TICKS = 1`, `comp_clean` follows `sync` one cycle later. No glitches are possible.
- `clear_count` zeroes `glitch_count` on the next edge. If a glitch increment occurs in the same cycle, the clear wins.
- The counters have these widths:
  - The filter counter is 16 bits and compares with `==` against `FILTER_TICKS`.
  - The blank counter is sized `$clog2(BLANK_TICKS+1)`, with a minimum of 1 bit.
- Reset values: every output is 0, all synchroniser flops are 0, the state is STABLE, and both counters are 0.
- Reset asserted mid-qualification or mid-blanking returns the block to these values immediately (asynchronously).

## Timing
- Let `comp_raw` change and then hold before sampling edge 1.
  - `sync` reflects the new value after edge `SYNC_STAGES`.
  - `comp_clean` changes on edge `SYNC_STAGES + FILTER_TICKS`.
  - The default latency is 18 cycles, which is 180 ns.
- `comp_rise` and `comp_fall` are registered and high for exactly the cycle in which the new `comp_clean` value is first visible.
- `blank_start` sampled on edge e:
  - `blanking` is 1 from edge e.
  - `blanking` is 0 after edge e + `BLANK_TICKS`.
  - Qualification can begin on the following edge.
- A pulse on `sync` lasting n cycles, with 1 ≤ n < `FILTER_TICKS`, outside blanking increments `glitch_count` by exactly 1. It does not alter `comp_clean`.
- All outputs come straight from flops; there is no combinational path from input to output.

## Structure
- `comp_cond_pkg` contains:
  - `typedef enum logic [1:0] {STABLE, QUALIFY, BLANK} state_t`.
  - The 16-bit filter-count width constant.
- One sub-module: `sync_chain`, a parameterised N-stage flop synchroniser with asynchronous reset. It is reused for other asynchronous pins.
- The top-level `comp_conditioner` holds the FSM, the filter counter, the blank counter, the edge registers and the glitch counter.

## Test plan
Bench parameters are `SYNC_STAGES=2`, `FILTER_TICKS=4`, `BLANK_TICKS=8`.
- Reset: hold `reset` for 3 cycles with `comp_raw=1` → all outputs are 0 during reset. After release, `comp_clean=1` with `comp_rise` pulsed on edge 6 counted from release.
- Step: `comp_raw` 0→1 held → `comp_clean` is 1 on edge 6 with a single `comp_rise` pulse. Then 1→0 held → `comp_fall` is 1 for one cycle.
- Glitch rejection: 3-cycle pulses ×5 → `comp_clean` stays 0 and `glitch_count=5`. Then pulse `clear_count` → `glitch_count=0`.
- Blanking: pulse `blank_start` at edge 10, toggle `comp_raw` at edge 11 and hold → `blanking` is high on edges 10–17. `comp_clean` does not change until edge ≥ 22. No glitch is counted.
- Retrigger and abort: `blank_start` at edge 10 and again at edge 15 → `blanking` is high through edge 22. A `blank_start` during QUALIFY → qualification is aborted and `glitch_count` is unchanged.
- Saturation: with `CNT_W=3`, inject 10 glitches → `glitch_count=7`. `clear_count` asserted in the same cycle as a glitch → 0.
